alu_arbiter: RTL

- Shares one combinational ALU (32-bit operands, func3/subsra encoding) among NUM_REQ requesters, e.g. integer execute and address generation.
- Per-requester valid/ready request ports feed a round-robin arbiter. The winner's operands drive the ALU, and the ALU result is captured into a one-entry output register tagged with the requester id.
- The ALU itself is instantiated by the parent and connected through the alu_* ports.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/alu_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbitration slice: operand widths, func3
// encodings, the per-requester request bundle and the control FSM states.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int F3_W  = 3;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] operand1;
        logic [ALU_W-1:0] operand2;
        logic [F3_W-1:0]  func3;
        logic             subsra;
    } alu_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps,
// so the first valid request at or after the pointer wins.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_en,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_idx
);

    logic           w_found;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_cand;
    logic [IDW-1:0] w_idx;

    // With no valid request the index falls back to the pointer so the
    // operand mux downstream stays deterministic.
    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        w_idx   = i_ptr;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            w_cand = w_sum[IDW-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = w_idx;
        if (w_found && i_en) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters through a
// round-robin arbiter, capturing each result in a one-entry tagged register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [ALU_W*NUM_REQ-1:0] i_req_operand1,
    input  logic [ALU_W*NUM_REQ-1:0] i_req_operand2,
    input  logic [F3_W*NUM_REQ-1:0]  i_req_func3,
    input  logic [NUM_REQ-1:0]       i_req_subsra,
    output logic [ALU_W-1:0]         o_alu_operand1,
    output logic [ALU_W-1:0]         o_alu_operand2,
    output logic [F3_W-1:0]          o_alu_func3,
    output logic                     o_alu_subsra,
    input  logic [ALU_W-1:0]         i_alu_result,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ALU_W-1:0]         o_rsp_result,
    output logic [IDW-1:0]           o_rsp_id,
    output logic                     o_busy
);

    arb_state_e     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_rsp_id;
    logic [ALU_W-1:0] r_rsp_result;
    logic           r_run;

    alu_req_t       w_req [NUM_REQ];
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0] w_gnt_idx;
    logic [IDW-1:0] w_next_ptr;
    logic           w_can_issue;
    logic           w_transfer;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_req[g].operand1 = i_req_operand1[ALU_W*g +: ALU_W];
        assign w_req[g].operand2 = i_req_operand2[ALU_W*g +: ALU_W];
        assign w_req[g].func3    = i_req_func3[F3_W*g +: F3_W];
        assign w_req[g].subsra   = i_req_subsra[g];
    end

    // r_run keeps ready low until the first edge after reset release.
    assign w_can_issue = r_run && ((r_state == EMPTY) || i_rsp_ready);

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_arbiter (
        .i_req     (i_req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_can_issue),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign o_req_ready = w_gnt;
    assign w_transfer  = |w_gnt;
    assign w_next_ptr  = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    assign o_alu_operand1 = w_req[w_gnt_idx].operand1;
    assign o_alu_operand2 = w_req[w_gnt_idx].operand2;
    assign o_alu_func3    = w_req[w_gnt_idx].func3;
    assign o_alu_subsra   = w_req[w_gnt_idx].subsra;

    // A transfer may refill the register in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_rr_ptr     <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_run        <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_transfer) begin
                r_state      <= FULL;
                r_rsp_result <= i_alu_result;
                r_rsp_id     <= w_gnt_idx;
                r_rr_ptr     <= w_next_ptr;
            end else if ((r_state == FULL) && i_rsp_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign o_rsp_valid  = (r_state == FULL);
    assign o_busy       = (r_state == FULL);
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_id     = r_rsp_id;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(o_req_ready));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_rsp_valid && !i_rsp_ready) |=> ($stable(o_rsp_result) && $stable(o_rsp_id)));

endmodule
